// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: pipeline-stage hazard inputs in, per-stage stall/flush
// controls plus status/performance counters out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ID_rs1;
  logic [4:0]       ID_rs2;
  logic             ID_UseRs1;
  logic             ID_UseRs2;
  logic [4:0]       EX_rd;
  logic             EX_MemRead;
  logic             EX_PCSrc;
  logic             EX_MulDivStart;
  logic             MulDivDone;
  logic             MEM_MemReq;
  logic             MEM_MemReady;

  logic             PC_Stall;
  logic             IF_ID_Stall;
  logic             IF_ID_Flush;
  logic             ID_EX_Stall;
  logic             ID_EX_Flush;
  logic             EX_MEM_Stall;
  logic             EX_MEM_Flush;
  logic             MEM_WB_Flush;
  logic             MD_Busy;
  logic             MemTimeout;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushCount;

  // Pipeline side: supplies hazard conditions, consumes controls.
  modport master (
    output ID_rs1, ID_rs2, ID_UseRs1, ID_UseRs2, EX_rd, EX_MemRead, EX_PCSrc,
           EX_MulDivStart, MulDivDone, MEM_MemReq, MEM_MemReady,
    input  PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall, ID_EX_Flush,
           EX_MEM_Stall, EX_MEM_Flush, MEM_WB_Flush, MD_Busy, MemTimeout,
           StallCycles, FlushCount
  );

  // Controller side.
  modport slave (
    input  ID_rs1, ID_rs2, ID_UseRs1, ID_UseRs2, EX_rd, EX_MemRead, EX_PCSrc,
           EX_MulDivStart, MulDivDone, MEM_MemReq, MEM_MemReady,
    output PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall, ID_EX_Flush,
           EX_MEM_Stall, EX_MEM_Flush, MEM_WB_Flush, MD_Busy, MemTimeout,
           StallCycles, FlushCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage core: load-use, branch redirect,
// multi-cycle mul/div occupancy and data-memory wait back-pressure.
module hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input logic         clk,
  input logic         rst_n,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {IDLE, MD_BUSY} md_state_e;

  localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);

  md_state_e        state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_timeout;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_count;

  logic memwait, lu, mdwait;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic ex_mem_stall, ex_mem_flush, mem_wb_flush;

  assign memwait = hz.MEM_MemReq & ~hz.MEM_MemReady;
  assign lu      = hz.EX_MemRead & (hz.EX_rd != 5'd0) &
                   ((hz.ID_UseRs1 & (hz.EX_rd == hz.ID_rs1)) |
                    (hz.ID_UseRs2 & (hz.EX_rd == hz.ID_rs2)));
  // A done pulse coincident with start (or while busy) releases EX this cycle.
  assign mdwait  = ((state == MD_BUSY) | ((state == IDLE) & hz.EX_MulDivStart)) &
                   ~hz.MulDivDone;

  // NOTE: every output gets a default before the priority chain, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (!rst_n) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (memwait) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (mdwait) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (hz.EX_PCSrc) begin
      // The redirect squashes the ID instruction, so any load-use is moot.
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (lu) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_flush  = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (hz.EX_MulDivStart & ~hz.MulDivDone & ~memwait) state_next = MD_BUSY;
      MD_BUSY: if (hz.MulDivDone) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state <= state_next;
      if (memwait) begin
        if (wait_cnt != WAIT_LIMIT) wait_cnt <= wait_cnt + 1'b1;
        // Set on the edge where the count reaches the limit.
        if (wait_cnt >= WAIT_LAST) mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (pc_stall && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
      if (if_id_flush && !(&flush_count)) flush_count <= flush_count + 1'b1;
    end
  end

  assign hz.PC_Stall     = pc_stall;
  assign hz.IF_ID_Stall  = if_id_stall;
  assign hz.IF_ID_Flush  = if_id_flush;
  assign hz.ID_EX_Stall  = id_ex_stall;
  assign hz.ID_EX_Flush  = id_ex_flush;
  assign hz.EX_MEM_Stall = ex_mem_stall;
  assign hz.EX_MEM_Flush = ex_mem_flush;
  assign hz.MEM_WB_Flush = mem_wb_flush;
  assign hz.MD_Busy      = rst_n & (state == MD_BUSY);
  assign hz.MemTimeout   = mem_timeout;
  assign hz.StallCycles  = stall_cycles;
  assign hz.FlushCount   = flush_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a reference model pushes expected outputs
// per driven cycle; they are popped and compared at the falling edge.
module tb_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int TO    = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs1, rs2;
    logic       use1, use2;
    logic [4:0] ex_rd;
    logic       memread, pcsrc, mdstart, mddone, memreq, memready;
  } stim_t;

  typedef struct packed {
    logic [7:0] ctrl;
    logic       md_busy, timeout;
    logic [CNT_W-1:0] sc, fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();
  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc_no = 0;
  exp_t sb_q[$];

  // Reference model state (after the most recent edge).
  logic m_busy, m_to;
  int   m_wait, m_sc, m_fc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc_no, got, exp);
    end
  endtask

  function automatic stim_t nop();
    stim_t s = '0;
    s.rst_n    = 1'b1;
    s.memready = 1'b1;
    return s;
  endfunction

  // ctrl bits: PC_S IFID_S IFID_F IDEX_S IDEX_F EXMEM_S EXMEM_F MEMWB_F
  function automatic logic [7:0] model_ctrl(input stim_t s, input logic busy);
    logic mw, md, hz_lu;
    mw    = s.memreq && !s.memready;
    md    = (busy || s.mdstart) && !s.mddone;
    hz_lu = s.memread && s.ex_rd != 0 &&
            ((s.use1 && s.ex_rd == s.rs1) || (s.use2 && s.ex_rd == s.rs2));
    if (!s.rst_n)  return 8'b0010_1011;
    if (mw)        return 8'b1101_0101;
    if (md)        return 8'b1101_0010;
    if (s.pcsrc)   return 8'b0010_1000;
    if (hz_lu)     return 8'b1100_1000;
    return 8'b0000_0000;
  endfunction

  task automatic drive(input stim_t s);
    rst_n             = s.rst_n;
    hz.ID_rs1         = s.rs1;
    hz.ID_rs2         = s.rs2;
    hz.ID_UseRs1      = s.use1;
    hz.ID_UseRs2      = s.use2;
    hz.EX_rd          = s.ex_rd;
    hz.EX_MemRead     = s.memread;
    hz.EX_PCSrc       = s.pcsrc;
    hz.EX_MulDivStart = s.mdstart;
    hz.MulDivDone     = s.mddone;
    hz.MEM_MemReq     = s.memreq;
    hz.MEM_MemReady   = s.memready;
  endtask

  // One clock cycle: drive, predict, sample at negedge, advance model.
  task automatic cyc(input stim_t s);
    exp_t e, got;
    logic mw;
    drive(s);
    e.ctrl    = model_ctrl(s, m_busy);
    e.md_busy = s.rst_n && m_busy;
    e.timeout = m_to;
    e.sc      = CNT_W'(m_sc);
    e.fc      = CNT_W'(m_fc);
    sb_q.push_back(e);
    @(negedge clk);
    got = sb_q.pop_front();
    check("ctrl", {hz.PC_Stall, hz.IF_ID_Stall, hz.IF_ID_Flush, hz.ID_EX_Stall,
                   hz.ID_EX_Flush, hz.EX_MEM_Stall, hz.EX_MEM_Flush, hz.MEM_WB_Flush},
          got.ctrl);
    check("md_busy", hz.MD_Busy, got.md_busy);
    check("timeout", hz.MemTimeout, got.timeout);
    check("stall_cycles", hz.StallCycles, got.sc);
    check("flush_count", hz.FlushCount, got.fc);
    mw = s.memreq && !s.memready;
    if (!s.rst_n) begin
      m_busy = 1'b0; m_to = 1'b0; m_wait = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (!m_busy) m_busy = s.mdstart && !s.mddone && !mw;
      else         m_busy = !s.mddone;
      if (mw) begin
        m_wait++;
        if (m_wait >= TO) m_to = 1'b1;
      end else begin
        m_wait = 0;
      end
      if (e.ctrl[7] && m_sc < CMAX) m_sc++;
      if (e.ctrl[5] && m_fc < CMAX) m_fc++;
    end
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  initial begin
    stim_t s;
    // Bring the DUT out of X with one reset edge before scoring begins.
    s = nop(); s.rst_n = 1'b0;
    drive(s);
    m_busy = 1'b0; m_to = 1'b0; m_wait = 0; m_sc = 0; m_fc = 0;
    @(posedge clk); #1;
    cyc(s);                                       // reset-state outputs

    // Load-use on rs1: one bubble, then clear.
    s = nop(); s.memread = 1; s.ex_rd = 5; s.rs1 = 5; s.rs2 = 1; s.use1 = 1; s.use2 = 1;
    cyc(s);
    cyc(nop());
    // Load-use on rs2 only; then rs1 match with UseRs1=0 (no hazard).
    s = nop(); s.memread = 1; s.ex_rd = 9; s.rs2 = 9; s.use2 = 1; cyc(s);
    s = nop(); s.memread = 1; s.ex_rd = 9; s.rs1 = 9; s.use1 = 0; cyc(s);
    // x0 destination never hazards; non-load never hazards.
    s = nop(); s.memread = 1; s.ex_rd = 0; s.rs1 = 0; s.use1 = 1; cyc(s);
    s = nop(); s.memread = 0; s.ex_rd = 7; s.rs1 = 7; s.use1 = 1; cyc(s);

    // Branch and load-use in the same cycle: flush wins, no stall.
    s = nop(); s.pcsrc = 1; s.memread = 1; s.ex_rd = 5; s.rs1 = 5; s.use1 = 1;
    cyc(s);
    cyc(nop());

    // Mul/div: done arrives on the 5th cycle of occupancy.
    s = nop(); s.mdstart = 1;
    for (int i = 0; i < 4; i++) cyc(s);
    s.mddone = 1; cyc(s);
    cyc(nop());
    // Same-cycle done: zero wait.
    s = nop(); s.mdstart = 1; s.mddone = 1; cyc(s);
    cyc(nop());

    // Memory wait over a taken branch, then the branch resolves.
    s = nop(); s.memreq = 1; s.memready = 0; s.pcsrc = 1;
    for (int i = 0; i < 3; i++) cyc(s);
    s.memready = 1; cyc(s);
    cyc(nop());

    // Start during memwait does not enter MD_BUSY; then busy, memwait, done during memwait.
    s = nop(); s.mdstart = 1; s.memreq = 1; s.memready = 0; cyc(s);
    s = nop(); s.mdstart = 1; cyc(s);
    s.memreq = 1; s.memready = 0; cyc(s);
    s.mddone = 1; cyc(s);
    s = nop(); s.mdstart = 1; cyc(s);              // back in IDLE: new op starts
    s.mddone = 1; cyc(s);

    // Timeout: 3 waits then ready (no timeout), then 6 waits (timeout after 4th).
    s = nop(); s.memreq = 1; s.memready = 0;
    for (int i = 0; i < 3; i++) cyc(s);
    cyc(nop());
    for (int i = 0; i < 6; i++) cyc(s);
    for (int i = 0; i < 3; i++) cyc(nop());       // stays sticky

    // Saturate StallCycles and FlushCount.
    for (int i = 0; i < 12; i++) cyc(s);
    s = nop(); s.pcsrc = 1;
    for (int i = 0; i < 18; i++) cyc(s);
    cyc(nop());

    // Reset in the middle of MD_BUSY.
    s = nop(); s.mdstart = 1; cyc(s); cyc(s);
    s.rst_n = 0; s.pcsrc = 1; cyc(s);
    s = nop(); s.mdstart = 1; s.mddone = 1; cyc(s);
    cyc(nop());
    s = nop(); s.memread = 1; s.ex_rd = 3; s.rs2 = 3; s.use2 = 1; cyc(s);
    cyc(nop());

    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
